// File: rtl/serial_pkg.sv
// Shared line levels and frame state encoding for the serial transmitter and
// the matching receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: reloads on load, flags the last clock of each period.
// bit_end_nxt_c is the value bit_end takes after the coming edge.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic bit_end,
    output logic bit_end_nxt_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end_q;

    // Count down to zero and hold there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign bit_end_nxt_c = (cnt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_end_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_nxt_c;
        end
    end

    assign bit_end = bit_end_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: idle-high line, start / LSB-first data /
// optional even parity / stop, each bit held CLKS_PER_BIT clocks.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int unsigned       BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              parity_q, parity_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_busy_q, tx_busy_d;
    logic              frame_done_q, frame_done_d;
    logic              load_c;
    logic              bit_end;
    logic              bit_end_nxt_c;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load_c),
        .bit_end       (bit_end),
        .bit_end_nxt_c (bit_end_nxt_c)
    );

    // Next state, datapath and registered line level derived from the next state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        load_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d   = tx_data;
                    parity_d  = ^tx_data;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                    load_c    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    load_c  = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    load_c = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    load_c  = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_out_d = START_BIT;
            ST_DATA:   tx_out_d = shift_d[0];
            ST_PARITY: tx_out_d = parity_d;
            ST_STOP:   tx_out_d = STOP_BIT;
            default:   tx_out_d = LINE_IDLE;
        endcase

        tx_ready_d = (state_d == ST_IDLE);
        tx_busy_d  = (state_d != ST_IDLE);
    end

    // Kept outside the block above so the timer feedback path stays acyclic.
    assign frame_done_d = (state_d == ST_STOP) && bit_end_nxt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            tx_out_q     <= LINE_IDLE;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            tx_out_q     <= tx_out_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_out     = tx_out_q;
    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default 8-bit/4-clock/parity instance and
// a 1-clock no-parity instance.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_out, tx_busy, frame_done;
    logic       tx_ready2, tx_out2, tx_busy2, frame_done2;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (4),
        .PARITY_EN    (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    serial_frame_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (1),
        .PARITY_EN    (0)
    ) u_dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .tx_out     (tx_out2),
        .tx_busy    (tx_busy2),
        .frame_done (frame_done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows the default instance through ncyc clocks of a frame already accepted.
    task automatic run_frame(input string name, input logic [7:0] d, input logic par,
                             input int ncyc, input bit glitch);
        logic exp_bit;
        int   b;
        for (int c = 0; c < ncyc; c++) begin
            b = c / 4;
            if (b == 0)      exp_bit = 1'b0;
            else if (b <= 8) exp_bit = d[b-1];
            else if (b == 9) exp_bit = par;
            else             exp_bit = 1'b1;
            chk($sformatf("%s tx_out c%0d", name, c), 32'(tx_out), 32'(exp_bit));
            chk($sformatf("%s tx_busy c%0d", name, c), 32'(tx_busy), 32'd1);
            chk($sformatf("%s tx_ready c%0d", name, c), 32'(tx_ready), 32'd0);
            chk($sformatf("%s frame_done c%0d", name, c), 32'(frame_done), 32'(c == 43));
            if (glitch && c == 10) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end
            if (glitch && c == 11) tx_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " idle tx_ready"}, 32'(tx_ready), 32'd1);
        chk({name, " idle tx_out"}, 32'(tx_out), 32'd1);
        chk({name, " idle tx_busy"}, 32'(tx_busy), 32'd0);
        chk({name, " idle frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    logic [9:0] seq_fast;

    initial begin
        rst_n     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;
        seq_fast  = 10'b1100101100;

        // Reset values, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset fast tx_out", 32'(tx_out2), 32'd1);
        chk("reset fast tx_ready", 32'(tx_ready2), 32'd1);
        chk("reset fast tx_busy", 32'(tx_busy2), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("post-reset");

        // 0xA5, parity 0
        send(8'hA5);
        run_frame("a5", 8'hA5, 1'b0, 44, 1'b0);
        chk_idle("a5");

        // 0x01, parity 1
        send(8'h01);
        run_frame("01", 8'h01, 1'b1, 44, 1'b0);
        chk_idle("01");

        // Mid-frame valid pulse and data change are ignored
        send(8'hC3);
        run_frame("glitch", 8'hC3, 1'b0, 44, 1'b1);
        chk_idle("glitch");

        // Back-to-back with valid held: exactly one idle cycle between frames
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hFF;
        run_frame("b2b 00", 8'h00, 1'b0, 44, 1'b0);
        chk_idle("b2b gap");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        run_frame("b2b ff", 8'hFF, 1'b0, 44, 1'b0);
        chk_idle("b2b ff");

        // Reset during data bit 3 of 0x3C takes effect without a clock edge
        send(8'h3C);
        run_frame("abort", 8'h3C, 1'b0, 18, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("abort async");
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort frame_done", 32'(frame_done), 32'd0);
            chk("abort tx_out", 32'(tx_out), 32'd1);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("abort released");
        send(8'h3C);
        run_frame("3c", 8'h3C, 1'b0, 44, 1'b0);
        chk_idle("3c");

        // One clock per bit, no parity: 10-cycle frame for 0x96
        tx_data2  = 8'h96;
        tx_valid2 = 1'b1;
        @(posedge clk); #1;
        tx_valid2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("fast tx_out c%0d", c), 32'(tx_out2), 32'(seq_fast[c]));
            chk($sformatf("fast tx_busy c%0d", c), 32'(tx_busy2), 32'd1);
            chk($sformatf("fast frame_done c%0d", c), 32'(frame_done2), 32'(c == 9));
            @(posedge clk); #1;
        end
        chk("fast idle tx_ready", 32'(tx_ready2), 32'd1);
        chk("fast idle tx_out", 32'(tx_out2), 32'd1);
        chk("fast idle frame_done", 32'(frame_done2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter. It is the driving end of the single-bit serial streams our flip-flop and shift-register cells capture.
- Accepts a DATA_W-bit word on a valid/ready handshake.
- Emits an idle-high, start/data/parity/stop frame on one registered output, one bit every CLKS_PER_BIT clocks.
- Sits in front of any serial receiver or capture flop in the design.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  word on tx_data is valid
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line, registered; idle level 1
tx_busy  output  1  frame in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (while rst_n=0, effective immediately): state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, frame_done=0. Shift register and counters are cleared.
- Reset mid-frame aborts the frame with no completion pulse. tx_out returns to 1 immediately.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Handshake: accept when tx_valid && tx_ready at a rising edge.
  - tx_data is latched into the shift register.
  - Even parity (XOR of all data bits) is computed at the same time.
  - The state moves to START.
  - tx_valid while not ready is ignored. tx_data changes after acceptance have no effect.
- Line levels by state:
  - IDLE: tx_out=1.
  - START: 0.
  - DATA: current LSB of the shift register; data is sent LSB-first and the register shifts right once per bit period.
  - PARITY: latched parity.
  - STOP: 1.
- Timing: every non-IDLE bit lasts exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
  - A DATA bit counter runs 0..DATA_W-1. The move to the next state happens when the bit counter = DATA_W-1 and the bit period ends.
- Latency: tx_out first reads 0 in the cycle after the accepting edge.
- Frame length: (DATA_W + PARITY_EN + 2) * CLKS_PER_BIT cycles.
- frame_done is high during the final STOP cycle. The next edge returns the block to IDLE.
- Back-to-back frames: with tx_valid held high, there is exactly one IDLE cycle (tx_out=1, tx_ready=1) between the end of STOP and the next START.
- CLKS_PER_BIT=1: each bit is one cycle and the counter stays at 0.
- Counter width: $clog2(CLKS_PER_BIT), minimum 1 bit.
- Outputs carry no X after reset. tx_out is always driven by a flop, never combinationally from tx_data.

Decomposition:
- Shared package serial_pkg:
  - state encoding localparams (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP);
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - The matching receiver reuses these.
- One sub-module, bit_timer: CLKS_PER_BIT down-counter with a load input and a one-cycle bit_end output. Same clk/rst_n.

Test Plan:
1. Defaults, send 0xA5 -> tx_out sequence 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each level held 4 cycles. Total 44 cycles. frame_done pulses once at cycle 44. tx_ready returns high the next cycle.
2. Send 0x01 -> data bits 1,0,0,0,0,0,0,0; parity bit 1; stop 1. tx_busy high for all 44 cycles.
3. tx_valid held high with 0x00, then 0xFF -> both frames correct (parity 0 for each). Exactly one idle-high cycle between the stop bit of 0x00 and the start bit of 0xFF.
4. Deassert rst_n during data bit 3 of 0x3C -> tx_out=1, tx_ready=1, tx_busy=0 without waiting for a clock edge. No frame_done. After release, a new 0x3C frame is sent complete and correct.
5. During a frame, pulse tx_valid and change tx_data to 0x00 -> no effect. The frame in flight still shows the original word, and tx_ready stays 0.
6. CLKS_PER_BIT=1, PARITY_EN=0, send 0x96 -> 10-cycle frame 0,0,1,1,0,1,0,0,1,1. frame_done in cycle 10.
